// File: rtl/instr_fetch.sv
// Two-word instruction fetch sequencer: reads opcode then operand from program memory and holds the pair for a consumer.
// Optional memory-timeout detection is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic        pc_read_enable,
  output logic        pc_enable,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] opcode,
  output logic [15:0] operand,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        flush,
  output logic [2:0]  fetch_state,
  output logic        fetch_error
);

  localparam int unsigned DW = 16;
  localparam int unsigned SW = 3;

  typedef enum logic [SW-1:0] {
    IDLE    = 3'd0,
    REQ_OP  = 3'd1,
    ADV_OP  = 3'd2,
    REQ_ARG = 3'd3,
    ADV_ARG = 3'd4,
    ISSUE   = 3'd5,
    ERROR   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic          adv_q, adv_d;
  logic          issue_q, issue_d;
  logic [DW-1:0] opcode_d, operand_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TW = 4;
  localparam logic [TW-1:0] TMO_MAX = '1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  // Next-state, capture and per-state output decode
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode;
    operand_d = operand;
`ifdef FETCH_TIMEOUT_EN
    tmo_d     = '0;
`endif
    case (state_q)
      IDLE:    state_d = REQ_OP;
      REQ_OP: begin
        if (mem_ack) begin
          opcode_d = mem_rdata;
          state_d  = ADV_OP;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TMO_MAX) state_d = ERROR;
`endif
        end
      end
      ADV_OP:  state_d = REQ_ARG;
      REQ_ARG: begin
        if (mem_ack) begin
          operand_d = mem_rdata;
          state_d   = ADV_ARG;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TMO_MAX) state_d = ERROR;
`endif
        end
      end
      ADV_ARG: state_d = ISSUE;
      ISSUE:   if (instr_ready) state_d = REQ_OP;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase

    // Flush beats everything, including a concurrent ack or consumer accept
    if (flush) begin
      state_d   = IDLE;
      opcode_d  = opcode;
      operand_d = operand;
`ifdef FETCH_TIMEOUT_EN
      tmo_d     = '0;
`endif
    end

    req_d   = (state_d == REQ_OP) || (state_d == REQ_ARG);
    adv_d   = (state_d == ADV_OP) || (state_d == ADV_ARG);
    issue_d = (state_d == ISSUE);
`ifdef FETCH_TIMEOUT_EN
    err_d   = (state_d == ERROR);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      adv_q   <= 1'b0;
      issue_q <= 1'b0;
      opcode  <= '0;
      operand <= '0;
`ifdef FETCH_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      adv_q   <= adv_d;
      issue_q <= issue_d;
      opcode  <= opcode_d;
      operand <= operand_d;
`ifdef FETCH_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  // A flush must kill the PC advance and the offered instruction in the same cycle
  assign pc_enable      = adv_q & ~flush;
  assign instr_valid    = issue_q & ~flush;
  assign mem_req        = req_q;
  assign pc_read_enable = req_q;
  assign mem_addr       = req_q ? pc : DW'(0);
  assign fetch_state    = SW'(state_q);

`ifdef FETCH_TIMEOUT_EN
  assign fetch_error = err_q;
`else
  assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized scoreboard run
// against a program-memory / external-PC model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset, mem_ack, instr_ready, flush;
  logic [15:0] pc, mem_rdata;
  logic        pc_read_enable, pc_enable, mem_req, instr_valid, fetch_error;
  logic [15:0] mem_addr, opcode, operand;
  logic [2:0]  fetch_state;

  instr_fetch dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_read_enable(pc_read_enable),
    .pc_enable(pc_enable), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .opcode(opcode), .operand(operand),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .flush(flush),
    .fetch_state(fetch_state), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Environment: external PC register, program memory with per-request ack delays
  logic [15:0] pc_m, salt;
  logic [15:0] fix_mem [logic [15:0]];
  int          dly_q[$];
  int          cur_dly, wait_cnt;
  bit          spurious;

  logic        s_pc_en, s_valid, s_req, s_pre, s_err, s_rdy;
  logic [15:0] s_addr, s_op, s_arg;
  logic [2:0]  s_state;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (fix_mem.exists(a)) return fix_mem[a];
    return {a[7:0], a[15:8]} ^ salt ^ 16'h3C5A;
  endfunction

  // Sample this cycle on the falling edge, clock it, then present next-cycle memory/PC inputs
  task automatic cycle();
    @(negedge clk);
    s_pc_en = pc_enable;  s_valid = instr_valid; s_req = mem_req; s_pre = pc_read_enable;
    s_err   = fetch_error; s_addr = mem_addr; s_op = opcode; s_arg = operand;
    s_state = fetch_state; s_rdy = instr_ready;
    @(posedge clk);
    if (s_pc_en) pc_m = pc_m + 16'd1;
    #1;
    pc = pc_m;
    if (mem_req) begin
      if (wait_cnt == 0) cur_dly = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
      wait_cnt++;
      mem_ack   = (wait_cnt > cur_dly);
      mem_rdata = mem_ack ? mem_val(pc_m) : 16'($urandom);
    end else begin
      wait_cnt  = 0;
      mem_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = 16'($urandom);
    end
  endtask

  task automatic do_reset(input logic [15:0] start_pc);
    reset = 1'b1; flush = 1'b0; instr_ready = 1'b0;
    dly_q.delete(); spurious = 1'b0;
    cycle();
    reset = 1'b0;
    pc_m = start_pc; pc = start_pc; wait_cnt = 0; mem_ack = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input string name);
    for (int i = 0; i < 40; i++) begin
      if (fetch_state == st) break;
      cycle();
    end
    checks++;
    if (fetch_state !== st) begin
      errors++; $display("FAIL %s_reach: state %0d expected %0d", name, fetch_state, st);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b1; instr_ready = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    pc = 16'h1234; pc_m = 16'h1234; wait_cnt = 0; spurious = 1'b0;
    cycle(); cycle();
    checks++;
    if (s_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", s_state); end
    checks++;
    if ({s_op, s_arg} !== 32'h0) begin errors++; $display("FAIL reset_words: got %h %h expected 0 0", s_op, s_arg); end
    checks++;
    if ({s_valid, s_req, s_pc_en, s_pre, s_err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {s_valid, s_req, s_pc_en, s_pre, s_err});
    end
    checks++;
    if (s_addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0000", s_addr); end
    // flush held in IDLE keeps the block idle
    reset = 1'b0;
    cycle(); cycle();
    checks++;
    if (s_state !== 3'd0) begin errors++; $display("FAIL idle_flush: state %0d expected 0", s_state); end
    flush = 1'b0;
    cycle(); cycle();
    checks++;
    if (s_state !== 3'd1 || s_req !== 1'b1) begin
      errors++; $display("FAIL idle_exit: state %0d req %b expected 1 1", s_state, s_req);
    end
  endtask

  task automatic test_basic();
    int t_req, t_val, pulses;
    fix_mem.delete();
    fix_mem[16'h0010] = 16'h7002; fix_mem[16'h0011] = 16'h0040;
    do_reset(16'h0010);
    instr_ready = 1'b1;
    t_req = -1; t_val = -1; pulses = 0;
    for (int i = 0; i < 20 && t_val < 0; i++) begin
      cycle();
      if (s_state == 3'd1 && t_req < 0) t_req = i;
      if (s_valid) t_val = i;
      if (s_pc_en) pulses++;
    end
    checks++;
    if (t_val < 0 || t_val - t_req != 4) begin
      errors++; $display("FAIL basic_latency: got %0d cycles expected 4", t_val - t_req);
    end
    checks++;
    if (s_op !== 16'h7002 || s_arg !== 16'h0040) begin
      errors++; $display("FAIL basic_data: got %h %h expected 7002 0040", s_op, s_arg);
    end
    checks++;
    if (pulses != 2 || pc_m !== 16'h0012) begin
      errors++; $display("FAIL basic_pc: pulses %0d pc %h expected 2 0012", pulses, pc_m);
    end
    fix_mem.delete();
  endtask

  task automatic test_ack_delay();
    int req_run, pulses;
    bit run_done, seen_arg, addr_bad, got;
    do_reset(16'h0020);
    dly_q.push_back(3); dly_q.push_back(0);
    instr_ready = 1'b0;
    req_run = 0; pulses = 0; run_done = 0; seen_arg = 0; addr_bad = 0; got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      cycle();
      if (s_req && !run_done) begin
        req_run++;
        if (s_addr !== 16'h0020) addr_bad = 1;
      end else if (req_run > 0) run_done = 1;
      if (s_state == 3'd3) seen_arg = 1;
      if (s_pc_en && !seen_arg) pulses++;
      got = s_valid;
    end
    checks++;
    if (req_run != 4) begin errors++; $display("FAIL delay_req_len: got %0d expected 4", req_run); end
    checks++;
    if (addr_bad) begin errors++; $display("FAIL delay_addr: got varying address expected 0020"); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL delay_pulses: got %0d expected 1", pulses); end
    checks++;
    if (!got || s_op !== mem_val(16'h0020) || s_arg !== mem_val(16'h0021)) begin
      errors++; $display("FAIL delay_data: got %h %h expected %h %h", s_op, s_arg, mem_val(16'h0020), mem_val(16'h0021));
    end
  endtask

  task automatic test_stall();
    logic [15:0] e_op, e_arg;
    bit got;
    do_reset(16'h0030);
    instr_ready = 1'b0;
    e_op = mem_val(16'h0030); e_arg = mem_val(16'h0031);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin cycle(); got = s_valid; end
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (!(s_valid === 1'b1 && s_op === e_op && s_arg === e_arg && s_req === 1'b0 && s_pc_en === 1'b0)) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid %b op %h arg %h req %b pc_en %b expected 1 %h %h 0 0",
                 i, s_valid, s_op, s_arg, s_req, s_pc_en, e_op, e_arg);
      end
    end
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    cycle();
    checks++;
    if (s_state !== 3'd1 || s_addr !== 16'h0032) begin
      errors++; $display("FAIL stall_release: state %0d addr %h expected 1 0032", s_state, s_addr);
    end
  endtask

  task automatic test_flush_arg();
    do_reset(16'h0040);
    dly_q.push_back(0); dly_q.push_back(2);
    wait_state(3'd3, "flush_arg");
    mem_ack = 1'b1; mem_rdata = 16'hBEEF; flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++;
    if (s_pc_en !== 1'b0) begin errors++; $display("FAIL flush_arg_pc_en: got %b expected 0", s_pc_en); end
    cycle();
    checks++;
    if (s_state !== 3'd0 || s_valid !== 1'b0) begin
      errors++; $display("FAIL flush_arg_idle: state %0d valid %b expected 0 0", s_state, s_valid);
    end
    checks++;
    if (s_arg !== 16'h0000 || s_op !== mem_val(16'h0040)) begin
      errors++; $display("FAIL flush_arg_words: got %h %h expected %h 0000", s_op, s_arg, mem_val(16'h0040));
    end
    cycle();
    checks++;
    if (s_state !== 3'd1 || pc_m !== 16'h0041) begin
      errors++; $display("FAIL flush_arg_restart: state %0d pc %h expected 1 0041", s_state, pc_m);
    end
  endtask

  task automatic test_flush_adv_issue();
    do_reset(16'h0050);
    wait_state(3'd2, "flush_adv");
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++;
    if (s_pc_en !== 1'b0) begin errors++; $display("FAIL flush_adv_pc_en: got %b expected 0", s_pc_en); end
    cycle();
    checks++;
    if (s_state !== 3'd0 || pc_m !== 16'h0050) begin
      errors++; $display("FAIL flush_adv_idle: state %0d pc %h expected 0 0050", s_state, pc_m);
    end
    wait_state(3'd5, "flush_issue");
    flush = 1'b1; instr_ready = 1'b1;
    cycle();
    flush = 1'b0; instr_ready = 1'b0;
    checks++;
    if (s_valid !== 1'b0) begin errors++; $display("FAIL flush_issue_valid: got %b expected 0", s_valid); end
    cycle();
    checks++;
    if (s_state !== 3'd0) begin errors++; $display("FAIL flush_issue_state: got %0d expected 0", s_state); end
  endtask

  task automatic test_reset_adv();
    do_reset(16'h0060);
    wait_state(3'd2, "reset_adv");
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    checks++;
    if ({s_state, s_pc_en, s_req, s_pre, s_valid, s_err, s_addr, s_op, s_arg} !== 56'h0) begin
      errors++;
      $display("FAIL reset_adv: state %0d pc_en %b req %b valid %b addr %h op %h arg %h expected all 0",
               s_state, s_pc_en, s_req, s_valid, s_addr, s_op, s_arg);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int reqs;
    bit got;
    do_reset(16'h0070);
    dly_q.push_back(1000);
    reqs = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      if (s_req) reqs++;
      got = (s_state == 3'd6);
    end
    checks++;
    if (!got || reqs != 15) begin errors++; $display("FAIL timeout_len: got %0d req cycles expected 15", reqs); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (s_state !== 3'd6 || s_err !== 1'b1 || s_req !== 1'b0 || s_valid !== 1'b0) begin
        errors++; $display("FAIL timeout_sticky: state %0d err %b req %b expected 6 1 0", s_state, s_err, s_req);
      end
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    checks++;
    if (s_state !== 3'd0 || s_err !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: state %0d err %b expected 0 0", s_state, s_err);
    end
  endtask
`else
  task automatic test_timeout();
    do_reset(16'h0070);
    dly_q.push_back(1000);
    for (int i = 0; i < 25; i++) cycle();
    checks++;
    if (s_state !== 3'd1 || s_req !== 1'b1 || s_err !== 1'b0) begin
      errors++; $display("FAIL no_timeout: state %0d req %b err %b expected 1 1 0", s_state, s_req, s_err);
    end
  endtask
`endif

  // Random ack delays, consumer back-pressure and stray acks; instructions must stream from consecutive words
  task automatic test_random();
    logic [15:0] exp_pc;
    int accepted, addr_bad;
    salt = 16'($urandom);
    do_reset(16'hFFF4);
    for (int i = 0; i < 80; i++) dly_q.push_back(int'($urandom_range(0, 3)));
    spurious = 1'b1;
    exp_pc = 16'hFFF4; accepted = 0; addr_bad = 0;
    for (int i = 0; i < 1500 && accepted < 30; i++) begin
      instr_ready = ($urandom_range(0, 2) != 0);
      cycle();
      if (s_req && s_addr !== pc_m) addr_bad++;
      if (!s_req && s_addr !== 16'h0) addr_bad++;
      if (s_valid && s_rdy) begin
        checks++;
        if (s_op !== mem_val(exp_pc) || s_arg !== mem_val(exp_pc + 16'd1)) begin
          errors++; $display("FAIL rand_data[%0d]: got %h %h expected %h %h", accepted, s_op, s_arg,
                              mem_val(exp_pc), mem_val(exp_pc + 16'd1));
        end
        checks++;
        if (pc_m !== exp_pc + 16'd2) begin
          errors++; $display("FAIL rand_pc[%0d]: got %h expected %h", accepted, pc_m, exp_pc + 16'd2);
        end
        exp_pc = exp_pc + 16'd2;
        accepted++;
      end
    end
    spurious = 1'b0;
    checks++;
    if (accepted != 30) begin errors++; $display("FAIL rand_count: got %0d expected 30", accepted); end
    checks++;
    if (addr_bad != 0) begin errors++; $display("FAIL rand_addr: got %0d bad cycles expected 0", addr_bad); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; instr_ready = 1'b0; mem_ack = 1'b0;
    mem_rdata = 16'h0; pc = 16'h0; pc_m = 16'h0; salt = 16'h0;
    wait_cnt = 0; cur_dly = 0; spurious = 1'b0;
    test_reset();
    test_basic();
    test_ack_delay();
    test_stall();
    test_flush_arg();
    test_flush_adv_issue();
    test_reset_adv();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
